// File: rtl/systolic_input_fifo_bank_pkg.sv
// Shared types for the systolic input FIFO bank: controller state encoding.
package cnn_fifo_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle,
    StFill,
    StDrain
  } state_e;

endpackage

// File: rtl/systolic_input_fifo_bank_if.sv
// Bus between the ROM stage / systolic array and the row-FIFO bank.
// The master modport drives the bank; the slave modport is the bank itself.
interface systolic_input_fifo_bank_if #(
  parameter int unsigned DataSize    = 16,
  parameter int unsigned ArraySize   = 9,
  parameter int unsigned DimDataSize = 16
);

  logic [DataSize-1:0]           bus;
  logic [ArraySize-1:0]          write_enable_in;
  logic                          fill_done;
  logic                          start;
  logic [DimDataSize-1:0]        drain_len;
  logic                          stall;
  logic [ArraySize*DataSize-1:0] data_out;
  logic [ArraySize-1:0]          valid_out;
  logic                          busy;
  logic                          done;
  logic                          overflow;
  logic                          underflow;

  modport master (
    output bus, write_enable_in, fill_done, start, drain_len, stall,
    input  data_out, valid_out, busy, done, overflow, underflow
  );

  modport slave (
    input  bus, write_enable_in, fill_done, start, drain_len, stall,
    output data_out, valid_out, busy, done, overflow, underflow
  );

endinterface

// File: rtl/systolic_input_fifo_bank_sync_fifo.sv
// Single-clock row FIFO with fall-through read port. A pop on empty is ignored;
// a push on full is accepted only when a real pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int unsigned DataSize  = 16,
  parameter int unsigned FifoDepth = 16,
  localparam int unsigned PtrW     = $clog2(FifoDepth)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic [DataSize-1:0] i_din,
  output logic [DataSize-1:0] o_dout,
  output logic                o_full,
  output logic                o_empty,
  output logic [PtrW:0]       o_count
);

  logic [DataSize-1:0] r_mem [FifoDepth];
  logic [PtrW-1:0]     r_wr_ptr;
  logic [PtrW-1:0]     r_rd_ptr;
  logic [PtrW:0]       r_count;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_full    = (r_count == (PtrW+1)'(FifoDepth));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (PtrW+1)'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - (PtrW+1)'(1);
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (reset && w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/systolic_input_fifo_bank.sv
// Row-FIFO bank feeding the systolic array's left edge with diagonal skew.
// Define ROM_LATENCY_COMP_EN to delay write_enable_in/fill_done by one cycle for a synchronous ROM.
module systolic_input_fifo_bank
  import cnn_fifo_pkg::*;
#(
  parameter int unsigned DataSize    = 16,
  parameter int unsigned ArraySize   = 9,
  parameter int unsigned FifoDepth   = 16,
  parameter int unsigned DimDataSize = 16
) (
  input logic                       clk,
  input logic                       reset,
  systolic_input_fifo_bank_if.slave s_if
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = DimDataSize + 1;

  state_e                        r_state, w_state_d;
  logic [CntW-1:0]               r_t, w_t_d;
  logic [DimDataSize-1:0]        r_len, w_len_d;
  logic                          w_done;
  logic [CntW-1:0]               w_t_end;
  logic [ArraySize-1:0]          w_we;
  logic                          w_fill_done;
  logic [ArraySize-1:0]          w_pop;
  logic [ArraySize-1:0]          w_full;
  logic [ArraySize-1:0]          w_empty;
  logic [ArraySize-1:0]          w_valid_d;
  logic [ArraySize-1:0]          w_drop;
  logic [DataSize-1:0]           w_dout  [ArraySize];
  logic [PtrW:0]                 w_count [ArraySize];
  logic [ArraySize*DataSize-1:0] r_data_out;
  logic [ArraySize-1:0]          r_valid_out;
  logic                          r_overflow;
  logic                          r_underflow;

`ifdef ROM_LATENCY_COMP_EN
  logic [ArraySize-1:0] r_we_dly;
  logic                 r_fill_done_dly;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_we_dly        <= '0;
      r_fill_done_dly <= 1'b0;
    end else begin
      r_we_dly        <= s_if.write_enable_in;
      r_fill_done_dly <= s_if.fill_done;
    end
  end

  assign w_we        = r_we_dly;
  assign w_fill_done = r_fill_done_dly;
`else
  assign w_we        = s_if.write_enable_in;
  assign w_fill_done = s_if.fill_done;
`endif

  // Last DRAIN cycle is the one where the bottom row's final word becomes visible.
  assign w_t_end = {1'b0, r_len} + CntW'(ArraySize - 1);

  always_comb begin
    w_state_d = r_state;
    w_t_d     = r_t;
    w_len_d   = r_len;
    w_done    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (s_if.start) w_state_d = StFill;
      end
      StFill: begin
        if (w_fill_done) begin
          w_state_d = StDrain;
          w_t_d     = '0;
          w_len_d   = s_if.drain_len;
        end
      end
      StDrain: begin
        if ((r_len == '0) || (!s_if.stall && (r_t == w_t_end))) begin
          w_done    = 1'b1;
          w_state_d = StIdle;
        end else if (!s_if.stall) begin
          w_t_d = r_t + CntW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
      r_t     <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_d;
      r_t     <= w_t_d;
      r_len   <= w_len_d;
    end
  end

  always_comb begin
    w_pop     = '0;
    w_valid_d = '0;
    w_drop    = '0;
    for (int i = 0; i < ArraySize; i++) begin
      w_pop[i] = (r_state == StDrain) && !s_if.stall && (r_t >= CntW'(i))
                 && (r_t < CntW'(i) + {1'b0, r_len});
      w_valid_d[i] = w_pop[i] && (w_count[i] != '0);
      // A full FIFO is never empty, so any scheduled pop frees the slot.
      w_drop[i] = w_we[i] && w_full[i] && !w_pop[i];
    end
  end

  for (genvar g = 0; g < ArraySize; g++) begin : g_row
    sync_fifo #(
      .DataSize (DataSize),
      .FifoDepth(FifoDepth)
    ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .i_push (w_we[g]),
      .i_pop  (w_pop[g]),
      .i_din  (s_if.bus),
      .o_dout (w_dout[g]),
      .o_full (w_full[g]),
      .o_empty(w_empty[g]),
      .o_count(w_count[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data_out  <= '0;
      r_valid_out <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_valid_out <= w_valid_d;
      for (int i = 0; i < ArraySize; i++) begin
        if (w_valid_d[i]) r_data_out[i*DataSize +: DataSize] <= w_dout[i];
      end
      if (|w_drop)           r_overflow  <= 1'b1;
      if (|(w_pop & w_empty)) r_underflow <= 1'b1;
    end
  end

  assign s_if.data_out  = r_data_out;
  assign s_if.valid_out = r_valid_out;
  assign s_if.busy      = (r_state != StIdle);
  assign s_if.done      = w_done;
  assign s_if.overflow  = r_overflow;
  assign s_if.underflow = r_underflow;

endmodule
